// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - plays a latched 2-bit colour sequence with on/off dwell timing
module sequence_player #(
    parameter int ON_CYCLES  = 8,
    parameter int OFF_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] sequence_in,
    input  logic [3:0]  sequence_len,
    output logic [1:0]  colour_out,
    output logic        colour_valid,
    output logic [3:0]  step_idx,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    // Counter holds cycles remaining after the current one, so a load of N-1 gives N cycles.
    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic [31:0]      seq_q, seq_d;
    logic [3:0]       len_q, len_d;
    logic [1:0]       colour_out_q, colour_out_d;
    logic             colour_valid_q, colour_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        seq_d   = seq_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    seq_d   = sequence_in;
                    len_d   = sequence_len;
                    step_d  = 4'd0;
                    cnt_d   = ON_LD;
                    state_d = (sequence_len == 4'd0) ? DONE : SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == '0) begin
                    if (step_q == 4'(len_q - 4'd1)) begin
                        state_d = DONE;
                    end else if (OFF_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = OFF_LD;
                    end else begin
                        step_d = step_q + 4'd1;
                        cnt_d  = ON_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = SHOW;
                    step_d  = step_q + 4'd1;
                    cnt_d   = ON_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = 4'd0;
            end
            default: begin
                state_d = IDLE;
                step_d  = 4'd0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            step_d  = 4'd0;
            cnt_d   = '0;
            seq_d   = seq_q;
            len_d   = len_q;
        end
        // Outputs are decoded from the next state so they appear registered with no extra lag.
        colour_valid_d = (state_d == SHOW);
        colour_out_d   = (state_d == SHOW) ? seq_d[{step_d, 1'b0} +: 2] : 2'b00;
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            step_q         <= 4'd0;
            seq_q          <= 32'd0;
            len_q          <= 4'd0;
            colour_out_q   <= 2'b00;
            colour_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            step_q         <= step_d;
            seq_q          <= seq_d;
            len_q          <= len_d;
            colour_out_q   <= colour_out_d;
            colour_valid_q <= colour_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign colour_out   = colour_out_q;
    assign colour_valid = colour_valid_q;
    assign step_idx     = step_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule
